// File: rtl/mds_mult.sv
// mds_mult: multiplies a 32-bit word Y by a fixed 4x4 MDS matrix over GF(2^8).
// The result is built over four cycles, one matrix column per cycle.
// All four columns share one scaling unit (x01, x5B, xEF).
module mds_mult #(
  parameter logic [8:0] POLY = 9'h169
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] y_reg;
  logic [31:0] acc;
  logic [31:0] out_reg;
  logic [1:0]  cnt;
  logic [7:0]  y_sel;
  logic [7:0]  y_x5b;
  logic [7:0]  y_xef;
  logic [31:0] col_term;
  logic [31:0] acc_next;

  // Shift-and-add GF(2^8) multiply. The constant operand folds it into a small XOR tree.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ POLY[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Select this cycle's input byte and scale it by the two non-trivial constants.
  always_comb begin
    y_sel = 8'h00;
    case (cnt)
      2'd0:    y_sel = y_reg[7:0];
      2'd1:    y_sel = y_reg[15:8];
      2'd2:    y_sel = y_reg[23:16];
      default: y_sel = y_reg[31:24];
    endcase
    y_x5b = gf_mul(y_sel, 8'h5B);
    y_xef = gf_mul(y_sel, 8'hEF);
  end

  // Route the scaled products into column cnt, packed as {z3, z2, z1, z0}.
  always_comb begin
    col_term = 32'h0;
    case (cnt)
      2'd0:    col_term = {y_xef, y_xef, y_x5b, y_sel};
      2'd1:    col_term = {y_sel, y_x5b, y_xef, y_xef};
      2'd2:    col_term = {y_xef, y_sel, y_xef, y_x5b};
      default: col_term = {y_x5b, y_xef, y_sel, y_x5b};
    endcase
    acc_next = acc ^ col_term;
  end

  // State register. Reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: accept in IDLE, run four columns in BUSY, hold in DONE until taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)   next_state = BUSY;
      BUSY:    if (cnt == 2'd3) next_state = DONE;
      DONE:    if (out_ready)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch the input word, accumulate one column per BUSY cycle, capture the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg   <= 32'h0;
      acc     <= 32'h0;
      out_reg <= 32'h0;
      cnt     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_reg <= in_data;
            acc   <= 32'h0;
            cnt   <= 2'd0;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) out_reg <= acc_next;
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs decode the state register only, so no input reaches them combinationally.
  // out_data comes from its own register, so it keeps its value after the word is taken.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_reg;

endmodule

// File: tb/tb_mds_mult.sv
// tb_mds_mult: self-checking bench for mds_mult.
// It uses directed vectors, multi-cycle corner sequences, and a random scoreboard run.
module tb_mds_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] y;
    logic [31:0] z;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  mds_mult dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Reference arithmetic: Horner-style GF multiply and a full row-by-column product.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return v[7] ? ({v[6:0], 1'b0} ^ 8'h69) : {v[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) r = xtime(r) ^ (a[i] ? b : 8'h00);
    return r;
  endfunction

  function automatic logic [31:0] ref_mds(input logic [31:0] y);
    logic [7:0]  m [4][4];
    logic [31:0] z;
    m = '{'{8'h01, 8'hEF, 8'h5B, 8'h5B},
          '{8'h5B, 8'hEF, 8'hEF, 8'h01},
          '{8'hEF, 8'h5B, 8'h01, 8'hEF},
          '{8'hEF, 8'h01, 8'hEF, 8'h5B}};
    z = 32'h0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        z[r*8 +: 8] = z[r*8 +: 8] ^ ref_mul(m[r][c], y[c*8 +: 8]);
    return z;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one word and wait for out_valid. edges counts clock edges from the accept edge.
  task automatic applyStimulus(input logic [31:0] y, input logic rdy, output int edges);
    in_data   = y;
    in_valid  = 1'b1;
    out_ready = rdy;
    next_cycle();
    edges = 1;
    in_valid = 1'b0;
    checkOutput("in_ready low in busy", 32'(in_ready), 32'd0);
    while (!out_valid && edges < 20) begin
      next_cycle();
      edges++;
    end
  endtask

  initial begin
    int   edges;
    int   sent;
    int   rcvd;
    int   guard;
    logic saw_valid;

    vecs[0] = '{32'h00000001, 32'hEFEF5B01};
    vecs[1] = '{32'h00000100, 32'h015BEFEF};
    vecs[2] = '{32'h00000002, 32'hB7B7B602};
    vecs[3] = '{32'h00000000, 32'h00000000};
    vecs[4] = '{32'h00010000, 32'hEF01EF5B};
    vecs[5] = '{32'h01000000, 32'h5BEF015B};
    vecs[6] = '{32'h00000003, 32'h5858ED03};
    vecs[7] = '{32'h00000101, 32'hEEB4B4EE};

    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) next_cycle();
    checkOutput("reset in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data",  out_data,       32'h0);
    rst = 1'b0;
    next_cycle();

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].y, 1'b1, edges);
      checkOutput("latency",  32'(edges), 32'd5);
      checkOutput("vector z", out_data,   vecs[i].z);
      next_cycle();
      checkOutput("in_ready after take",  32'(in_ready),  32'd1);
      checkOutput("out_valid after take", 32'(out_valid), 32'd0);
      checkOutput("out_data retained",    out_data,       vecs[i].z);
    end

    $display("[TB] output stall");
    applyStimulus(32'h00000002, 1'b0, edges);
    checkOutput("stall latency", 32'(edges), 32'd5);
    repeat (10) begin
      next_cycle();
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall out_data",  out_data,       32'hB7B7B602);
    end
    out_ready = 1'b1;
    next_cycle();
    checkOutput("release in_ready",  32'(in_ready),  32'd1);
    checkOutput("release out_valid", 32'(out_valid), 32'd0);

    $display("[TB] in_valid held with changing data");
    in_data = 32'h00000001; in_valid = 1'b1; out_ready = 1'b0;
    next_cycle();
    edges = 1;
    while (!out_valid && edges < 20) begin
      in_data = $urandom;
      next_cycle();
      edges++;
    end
    in_valid = 1'b0;
    checkOutput("held latency", 32'(edges), 32'd5);
    checkOutput("held z",       out_data,   32'hEFEF5B01);
    out_ready = 1'b1;
    next_cycle();
    checkOutput("held release in_ready", 32'(in_ready), 32'd1);

    $display("[TB] reset mid-busy");
    in_data = 32'h00000055; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h00000100;
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("mid reset in_ready",  32'(in_ready),  32'd1);
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid reset out_data",  out_data,       32'h0);
    saw_valid = 1'b0;
    repeat (8) begin
      next_cycle();
      if (out_valid) saw_valid = 1'b1;
    end
    checkOutput("no valid after reset", 32'(saw_valid), 32'd0);
    applyStimulus(32'h00000001, 1'b1, edges);
    checkOutput("post reset latency", 32'(edges), 32'd5);
    checkOutput("post reset z",       out_data,   32'hEFEF5B01);
    next_cycle();

    $display("[TB] random regression");
    exp_q.delete();
    sent = 0; rcvd = 0; guard = 0;
    while ((sent < 10000 || exp_q.size() != 0) && guard < 80000) begin
      in_data   = $urandom;
      in_valid  = (sent < 10000) && ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 7) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mds(in_data));
        sent++;
      end
      if (out_valid && out_ready) begin
        rcvd++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL random extra word: got %h, expected none", out_data);
        end else begin
          checkOutput("random z", out_data, exp_q.pop_front());
        end
      end
      next_cycle();
      guard++;
    end
    in_valid = 1'b0;
    checkOutput("random timeout",  32'(guard < 80000), 32'd1);
    checkOutput("random received", 32'(rcvd),          32'(sent));
    checkOutput("random sent",     32'(sent),          32'd10000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mds_mult.md
MDS_MULT -- requirements
Module: mds_mult

Interface
REQ-001 Parameter: POLY, 9'h169, GF(2^8) reduction polynomial x^8+x^6+x^5+x^3+1; the block SHALL be verified only at this default.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  32  word Y from the upstream q-permutation/key-XOR stage; y0 = Y[7:0] ... y3 = Y[31:24].
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 out_data  output  32  Z = MDS·Y; z0 = Z[7:0] ... z3 = Z[31:24].
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  downstream accepts out_data.

Function
REQ-010 Matrix rows z0..z3, columns y0..y3: [01 EF 5B 5B], [5B EF EF 01], [EF 5B 01 EF], [EF 01 EF 5B].
REQ-011 All byte products SHALL be GF(2^8) multiplies reduced by POLY; sums SHALL be XOR.
REQ-012 FSM states: IDLE, BUSY, DONE; the reset state SHALL be IDLE.
REQ-013 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-014 Input accept: in IDLE with in_valid=1 at an edge, latch in_data, clear the accumulator, set the column counter to 0, go to BUSY.
REQ-015 BUSY: each edge SHALL XOR (column[cnt] scaled by y_cnt) into the 32-bit accumulator and increment the 2-bit cnt.
REQ-016 The edge processing cnt=3 SHALL go to DONE; the accumulator then holds Z.
REQ-017 Latency: out_valid SHALL rise exactly 5 edges after the accept edge (1 accept + 4 BUSY).
REQ-018 Throughput: at most one word per 6 cycles when out_ready is held at 1.
REQ-019 DONE with out_ready=0: out_data and out_valid SHALL hold stable indefinitely.
REQ-020 DONE with out_ready=1 at an edge: go to IDLE; out_data SHALL retain its last value and out_valid SHALL drop.
REQ-021 in_valid outside IDLE SHALL be ignored; input data SHALL not be captured.
REQ-022 Changes on in_data after the accept edge SHALL not affect the result, because the latched copy is used.
REQ-023 The datapath SHALL use a single column-scaling unit (multiply by 01, 5B, EF), shared across cycles.
REQ-024 No combinational path SHALL exist from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, cnt=0, accumulator=0, latched input=0, out_data=0, out_valid=0, in_ready=1, regardless of state.
REQ-026 Reset in BUSY or DONE SHALL discard the word in flight; no out_valid pulse SHALL follow.
REQ-027 rst SHALL take priority over every handshake in the same cycle.

Verification
REQ-028 Y=32'h00000001 accepted, out_ready=1 -> out_valid 5 edges later, Z=32'hEFEF5B01, in_ready=1 the edge after.
REQ-029 Y=32'h00000100 -> Z=32'h015BEFEF; Y=32'h00000002 -> Z=32'hB7B7B602 (checks POLY reduction: 2·EF=B7).
REQ-030 Y=32'h0 -> Z=32'h0; then out_ready=0 for 10 cycles -> out_valid and out_data stable; release -> IDLE next edge.
REQ-031 in_valid held at 1 with a new Y each cycle during BUSY -> only the first word is processed; in_data toggled mid-BUSY -> result unchanged.
REQ-032 rst pulsed on the third BUSY cycle -> all outputs at reset values next edge, no out_valid; a subsequent Y=32'h00000001 still yields 32'hEFEF5B01.
REQ-033 Random regression of at least 10k words with random out_ready stalls against a bit-exact reference model -> zero mismatches, no lost or duplicated words.
